// File: rtl/stream_mux_arb_pkg.sv
// Shared types and constants for the stream_mux_arb slice.
package stream_mux_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past rr_ptr and wraps.
module rr_arbiter #(
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned CW       = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CW-1:0]       rr_ptr,
  output logic [CHANNELS-1:0] grant_oh,
  output logic [CW-1:0]       grant_idx,
  output logic                grant_any
);

  // First requester after rr_ptr, modulo CHANNELS; rr_ptr itself is searched last.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      idx = (32'(rr_ptr) + k) % CHANNELS;
      if (!grant_any && req[idx]) begin
        grant_any     = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream multiplexer with a registered output stage and
// packet-locked arbitration (fixed select or round-robin).
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter  int unsigned BITS     = 16,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned MODE     = MODE_FIXED,
  localparam int unsigned CW       = $clog2(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHANNELS*BITS-1:0] in_data,
  input  logic [CHANNELS-1:0]      in_valid,
  input  logic [CHANNELS-1:0]      in_last,
  output logic [CHANNELS-1:0]      in_ready,
  input  logic [CW-1:0]            sel,
  output logic [BITS-1:0]          out_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [CW-1:0]            out_chan,
  input  logic                     out_ready
);

  state_t                state;
  logic [CW-1:0]         lock_chan;
  logic [CW-1:0]         rr_ptr;
  logic [CHANNELS-1:0]   arb_oh;
  logic [CW-1:0]         arb_idx;
  logic                  arb_any;
  logic [CHANNELS-1:0]   grant_oh;
  logic [CW-1:0]         grant;
  logic                  space;
  logic                  xfer;
  logic [BITS-1:0]       mux_data;
  logic                  mux_last;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req       (in_valid),
    .rr_ptr    (rr_ptr),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  // Grant selection: locked owner, else fixed sel or round-robin winner.
  // grant_oh carries grant_valid implicitly (all-zero means no grant).
  always_comb begin
    grant_oh = '0;
    grant    = '0;
    if (state == ST_LOCKED) begin
      grant = lock_chan;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (CW'(i) == lock_chan) grant_oh[i] = 1'b1;
      end
    end else if (MODE == MODE_RR) begin
      if (arb_any) begin
        grant    = arb_idx;
        grant_oh = arb_oh;
      end
    end else begin
      grant = sel;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (CW'(i) == sel) grant_oh[i] = in_valid[i];
      end
    end
  end

  // Handshake: only the granted channel sees ready, and only when the output can accept.
  always_comb begin
    space    = !out_valid || out_ready;
    in_ready = space ? grant_oh : '0;
    xfer     = |(in_ready & in_valid);
  end

  // Data/last mux for the granted channel.
  always_comb begin
    mux_data = '0;
    mux_last = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (CW'(i) == grant) begin
        mux_data = in_data[i*BITS +: BITS];
        mux_last = in_last[i];
      end
    end
  end

  // Output register, packet-lock FSM and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lock_chan <= '0;
      rr_ptr    <= CW'(CHANNELS - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_last  <= mux_last;
        out_chan  <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (mux_last) begin
              rr_ptr <= grant;
            end else begin
              state     <= ST_LOCKED;
              lock_chan <= grant;
            end
          end
        end
        ST_LOCKED: begin
          if (xfer && mux_last) begin
            state  <= ST_IDLE;
            rr_ptr <= lock_chan;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: one round-robin and one fixed-select
// instance share the stimulus; each test checks the instance named by m_mode.
module tb_stream_mux_arb;

  localparam int unsigned BITS = 16;
  localparam int unsigned CH   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH*BITS-1:0] in_data;
  logic [CH-1:0]     in_valid, in_last;
  logic [1:0]        sel;
  logic              out_ready;

  logic [CH-1:0]     rr_ready, fx_ready;
  logic [BITS-1:0]   rr_data, fx_data;
  logic              rr_valid, fx_valid, rr_last, fx_last;
  logic [1:0]        rr_chan, fx_chan;

  always #5 clk = ~clk;

  stream_mux_arb #(.BITS(BITS), .CHANNELS(CH), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rr_ready), .sel(sel), .out_data(rr_data),
    .out_valid(rr_valid), .out_last(rr_last), .out_chan(rr_chan),
    .out_ready(out_ready)
  );

  stream_mux_arb #(.BITS(BITS), .CHANNELS(CH), .MODE(0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(fx_ready), .sel(sel), .out_data(fx_data),
    .out_valid(fx_valid), .out_last(fx_last), .out_chan(fx_chan),
    .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: packet owner (-1 = none), last served channel, output beat.
  int          m_mode;
  int          m_owner, m_ptr, m_oc;
  bit          m_ov, m_ol;
  logic [15:0] m_od;

  logic [CH-1:0]   d_ready;
  logic [BITS-1:0] d_data;
  logic            d_valid, d_last;
  logic [1:0]      d_chan;

  always_comb begin
    if (m_mode == 1) begin
      d_ready = rr_ready; d_data = rr_data; d_valid = rr_valid; d_last = rr_last; d_chan = rr_chan;
    end else begin
      d_ready = fx_ready; d_data = fx_data; d_valid = fx_valid; d_last = fx_last; d_chan = fx_chan;
    end
  end

  function automatic logic [3:0] exp_ready();
    if (m_ov && !out_ready) return 4'b0000;
    if (m_owner >= 0) return 4'(1 << m_owner);
    if (m_mode == 0) return in_valid[sel] ? 4'(1 << sel) : 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (in_valid[c]) return 4'(1 << c);
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 3; m_ov = 0; m_od = '0; m_ol = 0; m_oc = 0;
  endtask

  task automatic model_clock();
    logic [3:0] r;
    int g;
    r = exp_ready() & in_valid;
    g = -1;
    for (int i = 0; i < 4; i++) if (r[i]) g = i;
    if (g >= 0) begin
      m_ov = 1; m_od = in_data[g*16 +: 16]; m_ol = in_last[g]; m_oc = g;
      if (in_last[g]) begin m_owner = -1; m_ptr = g; end
      else m_owner = g;
    end else if (out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = '0; in_last = '0; in_data = '0; sel = '0; out_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    in_valid = '0; in_last = '0; in_data = '0; sel = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (rr_valid !== 1'b0 || fx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b/%b expected 0/0", rr_valid, fx_valid); end
    checks++; if (rr_data !== 16'h0 || fx_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0000", rr_data, fx_data); end
    checks++; if (rr_last !== 1'b0 || rr_chan !== 2'd0) begin errors++; $display("FAIL reset_last_chan: got %b/%0d expected 0/0", rr_last, rr_chan); end
    checks++; if (rr_ready !== 4'b0000 || fx_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b/%b expected 0000", rr_ready, fx_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_beat();
    m_mode = 1;
    do_reset();
    in_valid = 4'b0100; in_last = 4'b0100; in_data[47:32] = 16'hA5A5;
    #1;
    checks++; if (rr_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", rr_ready); end
    tick();
    in_valid = '0;
    checks++; if (rr_valid !== 1'b1 || rr_data !== 16'hA5A5) begin errors++; $display("FAIL single_data: got v=%b %h expected v=1 a5a5", rr_valid, rr_data); end
    checks++; if (rr_chan !== 2'd2 || rr_last !== 1'b1) begin errors++; $display("FAIL single_chan_last: got %0d/%b expected 2/1", rr_chan, rr_last); end
  endtask

  task automatic test_rr_fairness();
    logic [15:0] exp_d;
    m_mode = 1;
    do_reset();
    in_valid = 4'b1111; in_last = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      in_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      exp_d = in_data[(i % 4)*16 +: 16];
      tick();
      checks++; if (rr_valid !== 1'b1 || rr_chan !== 2'(i % 4) || rr_data !== exp_d) begin
        errors++; $display("FAIL rr_order[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h", i, rr_valid, rr_chan, rr_data, i % 4, exp_d);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_packet_lock();
    logic [3:0] vseq [6] = '{4'b0001, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0100};
    logic [3:0] lseq [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0100};
    int         cseq [6] = '{0, 1, 1, 1, 0, 2};
    m_mode = 1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      in_valid = vseq[k]; in_last = lseq[k];
      in_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      #1;
      checks++; if (rr_ready !== 4'(1 << cseq[k])) begin errors++; $display("FAIL lock_ready[%0d]: got %b expected %b", k, rr_ready, 4'(1 << cseq[k])); end
      tick();
      checks++; if (rr_chan !== 2'(cseq[k]) || rr_valid !== 1'b1 || rr_last !== lseq[k][cseq[k]]) begin
        errors++; $display("FAIL lock_chan[%0d]: got ch=%0d v=%b l=%b expected ch=%0d v=1 l=%b", k, rr_chan, rr_valid, rr_last, cseq[k], lseq[k][cseq[k]]);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [15:0] a, b;
    logic [15:0] seen[$];
    m_mode = 1;
    do_reset();
    a = 16'($urandom); b = ~a;
    in_valid = 4'b0001; in_last = 4'b0001; in_data[15:0] = a; out_ready = 1'b1;
    tick();
    in_data[15:0] = b; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rr_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, rr_ready); end
      tick();
      checks++; if (rr_valid !== 1'b1 || rr_data !== a) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %h expected v=1 %h", i, rr_valid, rr_data, a); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) in_valid = '0;
      if (rr_valid && out_ready) seen.push_back(rr_data);
      tick();
    end
    checks++; if (seen.size() != 2 || seen[0] !== a || seen[1] !== b) begin
      errors++; $display("FAIL bp_stream: got %0d beats first=%h expected 2 beats %h,%h", seen.size(), (seen.size() > 0) ? seen[0] : 16'h0, a, b);
    end
    checks++; if (rr_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got v=%b expected 0", rr_valid); end
  endtask

  task automatic test_fixed_select();
    logic [15:0] d3;
    m_mode = 0;
    do_reset();
    d3 = 16'($urandom);
    sel = 2'd3; in_valid = 4'b1001; in_last = 4'b0000;
    in_data = {d3, 16'h1111, 16'h2222, 16'h3333};
    #1;
    checks++; if (fx_ready !== 4'b1000) begin errors++; $display("FAIL fx_ready0: got %b expected 1000", fx_ready); end
    tick();
    checks++; if (fx_chan !== 2'd3 || fx_data !== d3) begin errors++; $display("FAIL fx_beat0: got ch=%0d %h expected ch=3 %h", fx_chan, fx_data, d3); end
    sel = 2'd0;
    #1;
    checks++; if (fx_ready !== 4'b1000) begin errors++; $display("FAIL fx_sel_ignored: got %b expected 1000", fx_ready); end
    tick();
    in_last = 4'b1001;
    tick();
    checks++; if (fx_chan !== 2'd3 || fx_last !== 1'b1) begin errors++; $display("FAIL fx_last: got ch=%0d l=%b expected ch=3 l=1", fx_chan, fx_last); end
    #1;
    checks++; if (fx_ready !== 4'b0001) begin errors++; $display("FAIL fx_switch: got %b expected 0001", fx_ready); end
    tick();
    checks++; if (fx_chan !== 2'd0 || fx_data !== 16'h3333) begin errors++; $display("FAIL fx_ch0: got ch=%0d %h expected ch=0 3333", fx_chan, fx_data); end
    in_valid = '0;
  endtask

  task automatic test_reset_mid_packet();
    m_mode = 1;
    do_reset();
    in_valid = 4'b0100; in_last = 4'b0000; in_data = {4{16'hBEEF}};
    tick();
    tick();
    checks++; if (rr_valid !== 1'b1 || rr_chan !== 2'd2) begin errors++; $display("FAIL mid_pre: got v=%b ch=%0d expected v=1 ch=2", rr_valid, rr_chan); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (rr_valid !== 1'b0) begin errors++; $display("FAIL mid_async: got v=%b expected 0", rr_valid); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 4'b1111; in_last = 4'b1111;
    #1;
    checks++; if (rr_ready !== 4'b0001) begin errors++; $display("FAIL mid_priority: got %b expected 0001", rr_ready); end
    tick();
    checks++; if (rr_chan !== 2'd0 || rr_valid !== 1'b1) begin errors++; $display("FAIL mid_first: got ch=%0d v=%b expected ch=0 v=1", rr_chan, rr_valid); end
    in_valid = '0;
  endtask

  task automatic test_random(input int mode, input int cycles);
    logic [3:0] er;
    m_mode = mode;
    do_reset();
    for (int n = 0; n < cycles; n++) begin
      checks++; if (d_valid !== m_ov || d_data !== m_od || d_last !== m_ol || d_chan !== 2'(m_oc)) begin
        errors++; $display("FAIL rand%0d_out[%0d]: got v=%b d=%h l=%b ch=%0d expected v=%b d=%h l=%b ch=%0d",
          mode, n, d_valid, d_data, d_last, d_chan, m_ov, m_od, m_ol, m_oc);
      end
      in_data   = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      in_valid  = 4'($urandom);
      for (int i = 0; i < 4; i++) in_last[i] = ($urandom_range(0, 2) == 0);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = exp_ready();
      checks++; if (d_ready !== er) begin errors++; $display("FAIL rand%0d_ready[%0d]: got %b expected %b", mode, n, d_ready, er); end
      tick();
    end
    in_valid = '0; out_ready = 1'b1;
  endtask

  initial begin
    m_mode = 1;
    model_reset();
    test_reset();
    test_single_beat();
    test_rr_fairness();
    test_packet_lock();
    test_backpressure();
    test_fixed_select();
    test_reset_mid_packet();
    test_random(1, 300);
    test_random(0, 300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel, BITS-wide stream multiplexer with valid/ready handshaking, a registered output stage, and packet-locked arbitration. Selection is either externally fixed or round-robin. It sits in the video datapath where several pixel/command sources share one downstream consumer. It replaces hand-built trees of 2:1 muxes with a single block that is parameterised in width and channel count.

## Interface

- BITS, 16, data width per channel
- CHANNELS, 4, number of input channels (2..16)
- MODE, 0, 0 = fixed select from `sel`; 1 = round-robin arbitration
- CW (localparam), $clog2(CHANNELS), channel index width

Ports:

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  CHANNELS*BITS  channel i occupies bits [i*BITS +: BITS]
- in_valid  in  CHANNELS  per-channel valid
- in_last  in  CHANNELS  per-channel end-of-packet flag
- in_ready  out  CHANNELS  per-channel ready (combinational)
- sel  in  CW  channel request in MODE 0; ignored in MODE 1
- out_data  out  BITS  registered data
- out_valid  out  1  registered valid
- out_last  out  1  registered end-of-packet
- out_chan  out  CW  registered source channel of the current beat
- out_ready  in  1  downstream ready

## Operation

- Reset state: out_valid=0, out_data=0, out_last=0, out_chan=0, FSM=IDLE, rr_ptr=CHANNELS-1 (channel 0 has first priority).
- `space` = !out_valid || out_ready.
- FSM states:
  - IDLE: no channel owns the output.
  - LOCKED: lock_chan owns the output until its last beat.
- Grant (combinational):
  - In LOCKED: grant = lock_chan.
  - In IDLE, MODE 0: grant = sel, valid only if in_valid[sel].
  - In IDLE, MODE 1: grant = first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo CHANNELS.
  - In IDLE with no requester: no grant; all in_ready = 0.
- in_ready[i] = (i == grant) && grant_valid && space. A non-granted channel never sees ready.
- Transfer on channel g = in_valid[g] && in_ready[g]. On transfer, the output register loads out_data, out_last, out_chan=g, out_valid=1.
- If out_ready=1 and there is no transfer: out_valid clears. out_data, out_last and out_chan hold their values.
- FSM transitions:
  - IDLE, transfer with in_last=0: go to LOCKED, lock_chan=g.
  - IDLE, transfer with in_last=1: stay in IDLE, rr_ptr=g (single-beat packet).
  - LOCKED, transfer with in_last=1: go to IDLE, rr_ptr=lock_chan.
  - LOCKED, no transfer or in_last=0: stay in LOCKED.
- Changes to `sel` or new requests during LOCKED are ignored until the packet completes.
- MODE 0 never updates rr_ptr in a way that affects behaviour.
- Asynchronous reset mid-packet: the packet is abandoned and the output beat is dropped (out_valid=0). The upstream source must restart the packet.

## Timing

- Latency: 1 cycle from an input transfer to out_valid.
- Throughput: 1 beat/cycle sustained while out_ready=1, including back-to-back packets from different channels. There is no idle cycle between packets.
- Backpressure: when out_valid=1 and out_ready=0, in_ready is all-zero that cycle and the output register holds stable.
- Rotation: a round-robin change of owner takes effect in the cycle after the last beat transfers.
- No combinational path from in_valid to out_*.
- Combinational paths exist from in_valid, sel and out_ready to in_ready.

## Structure

- Shared package/header holds:
  - FSM state encoding (ST_IDLE=1'b0, ST_LOCKED=1'b1).
  - MODE constants (MODE_FIXED=0, MODE_RR=1).
- Sub-module `rr_arbiter`, parameterised by CHANNELS:
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, encoded grant index, any-grant flag.
  - Purely combinational.
- Top level owns the FSM, lock_chan, rr_ptr and the output register.

## Test plan

- Reset and single beat: reset, then MODE 1, in_valid=4'b0100, data2=16'hA5A5, last=1. Expect in_ready=4'b0100; the next cycle gives out_data=A5A5, out_chan=2, out_last=1.
- Round-robin fairness: MODE 1, all four channels continuously valid with single-beat packets, out_ready=1. Expect out_chan sequence 0,1,2,3,0,... with no bubbles.
- Packet lock: channel 1 sends a 3-beat packet while channel 0 is also valid. Expect out_chan=1 for three consecutive beats, then channel 0, then channel 2 or 3 only after that.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1. Expect out_data stable, in_ready=0, and no beat lost or duplicated once out_ready returns to 1.
- Fixed-select mode: MODE 0, sel=3, in_valid=4'b1001. Expect only channel 3 served. Changing sel to 0 mid-packet has no effect until channel 3 asserts last.
- Reset mid-packet: assert rst_n=0 during a LOCKED packet. Expect out_valid=0 immediately. After release, channel 0 has first priority.
